// File: rtl/br_sequencer.sv
// br_sequencer: branch-resolution sequencer for the LC-3 datapath.
//
// When Start is seen in idle, the sequencer captures IR and the incremented PC.
// For a BR instruction it strobes LD_BEN, samples the returned BEN bit one
// cycle later and computes the PC-relative target. It then issues a single
// Done pulse, together with LD_PC when the branch is taken. Non-BR
// instructions complete on the next cycle as not-taken.
//
// Optional build macro: BRSEQ_STATS_EN enables saturating BR/taken counters.
// Without it, Br_Count and Taken_Count are tied to zero.
//
// Ports:
//   Clk          in   system clock, rising-edge
//   Reset        in   synchronous active-high reset
//   Start        in   resolve request, honoured only while idle
//   IR[15:0]     in   instruction word, captured on accepted Start
//   PC[15:0]     in   incremented PC, captured on accepted Start
//   BEN          in   branch-enable register output, valid the cycle after LD_BEN
//   LD_BEN       out  one-cycle load strobe to the branch-enable register
//   LD_PC        out  one-cycle load strobe to the PC register (taken only)
//   PC_next      out  next PC value, valid while Done=1
//   Taken        out  branch decision, valid while Done=1
//   Done         out  one-cycle completion pulse
//   Busy         out  high whenever the sequencer is not idle
//   Br_Count     out  BR instructions resolved
//   Taken_Count  out  taken branches

module br_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IR,
    input  logic [15:0] PC,
    input  logic        BEN,
    output logic        LD_BEN,
    output logic        LD_PC,
    output logic [15:0] PC_next,
    output logic        Taken,
    output logic        Done,
    output logic        Busy,
    output logic [15:0] Br_Count,
    output logic [15:0] Taken_Count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLdBen = 2'd1,
        StEval  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic        taken_q, taken_d;

    // Output registers, loaded from next-state so they line up with the state.
    logic        ld_ben_q, ld_ben_d;
    logic        ld_pc_q, ld_pc_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        taken_out_q, taken_out_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        target_d = target_q;
        taken_d  = taken_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    ir_d    = IR;
                    pc_d    = PC;
                    taken_d = 1'b0;
                    if (IR[15:12] == 4'b0000) begin
                        state_d = StLdBen;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLdBen: begin
                state_d = StEval;
            end
            StEval: begin
                taken_d  = BEN;
                // The 9-bit PC offset is sign-extended; the sum wraps modulo 2^16.
                target_d = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
                state_d  = StDone;
            end
            StDone: begin
                // A Start seen here is dropped, not queued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-state logic
    always_comb begin
        ld_ben_d    = (state_d == StLdBen);
        done_d      = (state_d == StDone);
        busy_d      = (state_d != StIdle);
        taken_out_d = (state_d == StDone) && taken_d;
        ld_pc_d     = (state_d == StDone) && taken_d;
        pc_next_d   = 16'h0000;
        if (state_d == StDone) begin
            pc_next_d = taken_d ? target_d : pc_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            ir_q        <= 16'h0000;
            pc_q        <= 16'h0000;
            target_q    <= 16'h0000;
            taken_q     <= 1'b0;
            ld_ben_q    <= 1'b0;
            ld_pc_q     <= 1'b0;
            pc_next_q   <= 16'h0000;
            taken_out_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            taken_q     <= taken_d;
            ld_ben_q    <= ld_ben_d;
            ld_pc_q     <= ld_pc_d;
            pc_next_q   <= pc_next_d;
            taken_out_q <= taken_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign LD_BEN  = ld_ben_q;
    assign LD_PC   = ld_pc_q;
    assign PC_next = pc_next_q;
    assign Taken   = taken_out_q;
    assign Done    = done_q;
    assign Busy    = busy_q;

`ifdef BRSEQ_STATS_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] taken_count_q, taken_count_d;

    // Counters advance in the completion cycle and stick at all-ones.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (state_q == StDone) begin
            if ((ir_q[15:12] == 4'b0000) && (br_count_q != 16'hFFFF)) begin
                br_count_d = br_count_q + 16'd1;
            end
            if (taken_q && (taken_count_q != 16'hFFFF)) begin
                taken_count_d = taken_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            br_count_q    <= 16'h0000;
            taken_count_q <= 16'h0000;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign Br_Count    = br_count_q;
    assign Taken_Count = taken_count_q;
`else
    assign Br_Count    = 16'h0000;
    assign Taken_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_br_sequencer.sv
// Directed bench for br_sequencer: table of single requests with hand-computed
// results, plus hand-written sequences for Start held busy, reset mid-flight
// and the statistics counters.

module tb_br_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] IR;
    logic [15:0] PC;
    logic        BEN;
    logic        LD_BEN;
    logic        LD_PC;
    logic [15:0] PC_next;
    logic        Taken;
    logic        Done;
    logic        Busy;
    logic [15:0] Br_Count;
    logic [15:0] Taken_Count;

    br_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .IR         (IR),
        .PC         (PC),
        .BEN        (BEN),
        .LD_BEN     (LD_BEN),
        .LD_PC      (LD_PC),
        .PC_next    (PC_next),
        .Taken      (Taken),
        .Done       (Done),
        .Busy       (Busy),
        .Br_Count   (Br_Count),
        .Taken_Count(Taken_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int ldpc_cnt = 0;
    int m_br = 0;
    int m_tk = 0;

    always @(negedge Clk) begin
        if (Done === 1'b1) done_cnt++;
        if (LD_PC === 1'b1) ldpc_cnt++;
    end

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic        ben;
        logic        exp_taken;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int m);
`ifdef BRSEQ_STATS_EN
        return m[15:0];
`else
        return (m == -1) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, " br_count"}, Br_Count, exp_cnt(m_br));
        chk({tag, " taken_count"}, Taken_Count, exp_cnt(m_tk));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_br = 0;
        m_tk = 0;
    endtask

    // One request: BEN carries the wrong value except in the cycle it must be sampled,
    // and IR/PC are scrambled right after acceptance.
    task automatic run_vec(input vec_t v, input int idx);
        logic  br;
        string n;
        br = (v.ir[15:12] == 4'b0000);
        n  = $sformatf("v%0d", idx);
        @(negedge Clk);
        Start = 1'b1;
        IR    = v.ir;
        PC    = v.pc;
        BEN   = ~v.ben;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        IR    = ~v.ir;
        PC    = ~v.pc;
        @(negedge Clk);
        if (br) begin
            chk({n, " ld_ben t+1"}, LD_BEN, 1);
            chk({n, " busy t+1"}, Busy, 1);
            chk({n, " done t+1"}, Done, 0);
            @(negedge Clk);
            chk({n, " ld_ben t+2"}, LD_BEN, 0);
            chk({n, " done t+2"}, Done, 0);
            BEN = v.ben;
            @(negedge Clk);
            BEN = ~v.ben;
            m_br++;
        end else begin
            chk({n, " ld_ben nonbr"}, LD_BEN, 0);
        end
        chk({n, " done"}, Done, 1);
        chk({n, " busy"}, Busy, 1);
        chk({n, " taken"}, Taken, v.exp_taken);
        chk({n, " ld_pc"}, LD_PC, v.exp_taken);
        chk({n, " pc_next"}, PC_next, v.exp_next);
        if (v.exp_taken) m_tk++;
        @(negedge Clk);
        chk({n, " idle busy"}, Busy, 0);
        chk({n, " idle done"}, Done, 0);
        chk({n, " idle ld_pc"}, LD_PC, 0);
    endtask

    initial begin
        int d0;
        int p0;

        vecs[0] = '{16'h0E05, 16'h3001, 1'b1, 1'b1, 16'h3006};
        vecs[1] = '{16'h09FE, 16'h3001, 1'b0, 1'b0, 16'h3001};
        vecs[2] = '{16'h09FE, 16'h3001, 1'b1, 1'b1, 16'h2FFF};
        vecs[3] = '{16'h0E01, 16'hFFFF, 1'b1, 1'b1, 16'h0000};
        vecs[4] = '{16'h1021, 16'h4000, 1'b1, 1'b0, 16'h4000};
        vecs[5] = '{16'h0000, 16'h1234, 1'b0, 1'b0, 16'h1234};
        vecs[6] = '{16'h0F00, 16'h0200, 1'b1, 1'b1, 16'h0100};
        vecs[7] = '{16'h5020, 16'h1111, 1'b0, 1'b0, 16'h1111};

        Reset = 1'b1;
        Start = 1'b0;
        IR    = 16'h0000;
        PC    = 16'h0000;
        BEN   = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset ld_ben", LD_BEN, 0);
        chk("reset ld_pc", LD_PC, 0);
        chk("reset pc_next", PC_next, 16'h0000);
        chk("reset taken", Taken, 0);
        chk("reset done", Done, 0);
        chk("reset busy", Busy, 0);
        chk_counters("reset");
        Reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end
        chk_counters("table");

        // Non-BR with Start still high in the completion cycle: one Done only.
        d0 = done_cnt;
        @(negedge Clk);
        Start = 1'b1;
        IR    = 16'h1021;
        PC    = 16'h4000;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("hold nonbr dones", 16'(done_cnt - d0), 1);

        // BR with Start held through all busy cycles: one Done, one LD_PC.
        d0 = done_cnt;
        p0 = ldpc_cnt;
        @(negedge Clk);
        Start = 1'b1;
        IR    = 16'h0E05;
        PC    = 16'h3001;
        BEN   = 1'b1;
        repeat (4) @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("hold br dones", 16'(done_cnt - d0), 1);
        chk("hold br ld_pcs", 16'(ldpc_cnt - p0), 1);

        // Reset while in the evaluate state drops the request.
        @(negedge Clk);
        Start = 1'b1;
        IR    = 16'h0E05;
        PC    = 16'h3001;
        BEN   = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        d0 = done_cnt;
        p0 = ldpc_cnt;
        @(negedge Clk);
        Reset = 1'b0;
        m_br = 0;
        m_tk = 0;
        chk("rst_eval busy", Busy, 0);
        chk("rst_eval done", Done, 0);
        chk("rst_eval ld_pc", LD_PC, 0);
        chk("rst_eval ld_ben", LD_BEN, 0);
        chk("rst_eval taken", Taken, 0);
        chk("rst_eval pc_next", PC_next, 16'h0000);
        chk_counters("rst_eval");
        repeat (4) @(negedge Clk);
        chk("rst_eval no done", 16'(done_cnt - d0), 0);
        chk("rst_eval no ld_pc", 16'(ldpc_cnt - p0), 0);
        run_vec(vecs[0], 100);

        // Three BRs (two taken) and one ADD from a clean reset.
        do_reset();
        run_vec(vecs[0], 200);
        run_vec(vecs[1], 201);
        run_vec(vecs[3], 202);
        run_vec(vecs[4], 203);
`ifdef BRSEQ_STATS_EN
        chk("stats br=3", Br_Count, 16'd3);
        chk("stats taken=2", Taken_Count, 16'd2);
`else
        chk("stats br off", Br_Count, 16'd0);
        chk("stats taken off", Taken_Count, 16'd0);
`endif
        chk_counters("stats");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
